// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / writeback stage in front of an 8-bit combinational ALU.
// Operands forward from the in-flight ALU result so dependent instructions issue back-to-back.
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_instr,
    output logic             in_ready,
    input  logic             hold,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             wb_valid,
    output logic [1:0]       wb_rd,
    output logic [7:0]       wb_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             illegal_op,
    input  logic [1:0]       dbg_sel,
    output logic [7:0]       dbg_data,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [2:0]       OP_LAST_LEGAL = 3'b100;
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    // Select the in-flight result instead of the register file when it targets rs.
    function automatic logic [7:0] fwd_sel(
        input logic [1:0] rs,
        input logic [7:0] rf_val,
        input logic       fwd_en,
        input logic [1:0] fwd_rd,
        input logic [7:0] fwd_val
    );
        logic [7:0] res;
        if (fwd_en && (fwd_rd == rs)) begin
            res = fwd_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    logic [2:0]       dec_op_s;
    logic [1:0]       dec_rd_s;
    logic [1:0]       dec_rs1_s;
    logic [1:0]       dec_rs2_s;
    logic             dec_imm_sel_s;
    logic [7:0]       dec_imm_s;
    logic             accept_s;
    logic             commit_s;
    logic             fwd_en_s;

    logic [3:0][7:0]  rf_q,          rf_d;
    logic             exe_valid_q,   exe_valid_d;
    logic             exe_legal_q,   exe_legal_d;
    logic [1:0]       exe_rd_q,      exe_rd_d;
    logic [7:0]       alu_a_q,       alu_a_d;
    logic [7:0]       alu_b_q,       alu_b_d;
    logic [2:0]       alu_op_q,      alu_op_d;
    logic             wb_valid_q,    wb_valid_d;
    logic [1:0]       wb_rd_q,       wb_rd_d;
    logic [7:0]       wb_data_q,     wb_data_d;
    logic             flag_z_q,      flag_z_d;
    logic             flag_n_q,      flag_n_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;

    assign dec_op_s      = in_instr[15:13];
    assign dec_rd_s      = in_instr[12:11];
    assign dec_rs1_s     = in_instr[10:9];
    assign dec_imm_sel_s = in_instr[8];
    assign dec_imm_s     = in_instr[7:0];
    assign dec_rs2_s     = in_instr[1:0];

    assign in_ready = !hold && !rst;
    assign accept_s = in_valid && in_ready;
    assign commit_s = exe_valid_q && !hold;
    assign fwd_en_s = exe_valid_q && exe_legal_q && (exe_rd_q != 2'd0);

    // Next-state for issue register, writeback, flags, register file and counter.
    always_comb begin
        rf_d        = rf_q;
        exe_valid_d = exe_valid_q;
        exe_legal_d = exe_legal_q;
        exe_rd_d    = exe_rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;

        if (accept_s) begin
            exe_valid_d = 1'b1;
            exe_legal_d = (dec_op_s <= OP_LAST_LEGAL);
            exe_rd_d    = dec_rd_s;
            alu_op_d    = dec_op_s;
            alu_a_d     = fwd_sel(dec_rs1_s, rf_q[dec_rs1_s], fwd_en_s, exe_rd_q, alu_out);
            if (dec_imm_sel_s) begin
                alu_b_d = dec_imm_s;
            end else begin
                alu_b_d = fwd_sel(dec_rs2_s, rf_q[dec_rs2_s], fwd_en_s, exe_rd_q, alu_out);
            end
            cnt_d = cnt_q + CNT_ONE;
        end else if (!hold) begin
            exe_valid_d = 1'b0;
        end else begin
            exe_valid_d = exe_valid_q;
        end

        // An illegal instruction retires silently apart from the sticky error.
        if (commit_s) begin
            if (exe_legal_q) begin
                if (exe_rd_q != 2'd0) begin
                    rf_d[exe_rd_q] = alu_out;
                end else begin
                    rf_d = rf_q;
                end
                flag_z_d   = alu_z;
                flag_n_d   = alu_n;
                wb_valid_d = 1'b1;
                wb_rd_d    = exe_rd_q;
                wb_data_d  = alu_out;
            end else begin
                illegal_d = 1'b1;
            end
        end else begin
            wb_valid_d = 1'b0;
        end

        rf_d[0] = 8'h00;
    end

    // State registers; reset discards any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q        <= '0;
            exe_valid_q <= 1'b0;
            exe_legal_q <= 1'b0;
            exe_rd_q    <= 2'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_op_q    <= 3'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 2'd0;
            wb_data_q   <= 8'h00;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rf_q        <= rf_d;
            exe_valid_q <= exe_valid_d;
            exe_legal_q <= exe_legal_d;
            exe_rd_q    <= exe_rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
    assign illegal_op  = illegal_q;
    assign issue_count = cnt_q;
    assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU closing the loop.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        hold;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_z;
    logic        alu_n;
    logic        wb_valid;
    logic [1:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        flag_z;
    logic        flag_n;
    logic        illegal_op;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [15:0] issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .hold(hold), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .alu_z(alu_z), .alu_n(alu_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flag_z(flag_z), .flag_n(flag_n), .illegal_op(illegal_op), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data), .issue_count(issue_count)
    );

    // Reference ALU; illegal opcodes return zero so a wrong flag commit would set Z.
    always_comb begin
        case (alu_op)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b010:  alu_out = alu_a & alu_b;
            3'b011:  alu_out = alu_a | alu_b;
            3'b100:  alu_out = alu_a ^ alu_b;
            default: alu_out = 8'h00;
        endcase
    end
    assign alu_z = (alu_out == 8'h00);
    assign alu_n = alu_out[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; hold = 1'b0; dbg_sel = 2'd0;
        step(); step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_checks++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin n_fail++; $display("FAIL rst_alu got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
        n_checks++; if ({wb_valid, wb_rd, wb_data, flag_z, flag_n, illegal_op} !== 14'd0) begin n_fail++; $display("FAIL rst_wb got %b %h %h %b%b%b want 0", wb_valid, wb_rd, wb_data, flag_z, flag_n, illegal_op); end
        n_checks++; if (issue_count !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", issue_count); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_imm();
        // ADD R1 = R0 + 5
        in_valid = 1'b1; in_instr = 16'h0905; dbg_sel = 2'd1;
        step();
        in_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_op} !== {8'h00, 8'h05, 3'b000}) begin n_fail++; $display("FAIL add_issue got %h/%h/%h want 00/05/0", alu_a, alu_b, alu_op); end
        n_checks++; if (issue_count !== 16'd1) begin n_fail++; $display("FAIL add_count got %0d want 1", issue_count); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_wb got %b want 0", wb_valid); end
        step();
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 8'h05}) begin n_fail++; $display("FAIL add_wb got %b/%h/%h want 1/1/05", wb_valid, wb_rd, wb_data); end
        n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b%b want 00", flag_z, flag_n); end
        n_checks++; if (dbg_data !== 8'h05) begin n_fail++; $display("FAIL add_r1 got %h want 05", dbg_data); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb_pulse got %b want 0", wb_valid); end
    endtask

    task automatic test_back_to_back();
        // ADD R1=0x0A; SUB R2=R1-7; ADD R1=5; SUB R2=R1-7, issued on consecutive edges
        in_valid = 1'b1; in_instr = 16'h090A;
        step();
        in_instr = 16'h3307;
        step();
        n_checks++; if ({alu_a, alu_b, alu_op} !== {8'h0A, 8'h07, 3'b001}) begin n_fail++; $display("FAIL b2b_fwd1 got %h/%h/%h want 0a/07/1", alu_a, alu_b, alu_op); end
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 8'h0A}) begin n_fail++; $display("FAIL b2b_wb0 got %b/%h/%h want 1/1/0a", wb_valid, wb_rd, wb_data); end
        in_instr = 16'h0905;
        step();
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd2, 8'h03}) begin n_fail++; $display("FAIL b2b_wb1 got %b/%h/%h want 1/2/03", wb_valid, wb_rd, wb_data); end
        in_instr = 16'h3307;
        step();
        in_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h07, 3'b001}) begin n_fail++; $display("FAIL b2b_fwd2 got %h/%h/%h want 05/07/1", alu_a, alu_b, alu_op); end
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 8'h05}) begin n_fail++; $display("FAIL b2b_wb2 got %b/%h/%h want 1/1/05", wb_valid, wb_rd, wb_data); end
        step();
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd2, 8'hFE}) begin n_fail++; $display("FAIL b2b_wb3 got %b/%h/%h want 1/2/fe", wb_valid, wb_rd, wb_data); end
        n_checks++; if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL b2b_flags got %b%b want 01", flag_z, flag_n); end
        dbg_sel = 2'd2; #1;
        n_checks++; if (dbg_data !== 8'hFE) begin n_fail++; $display("FAIL b2b_r2 got %h want fe", dbg_data); end
        n_checks++; if (issue_count !== 16'd5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", issue_count); end
    endtask

    task automatic test_xor_reg();
        // XOR R3 = R1 ^ R1
        in_valid = 1'b1; in_instr = 16'h9A01; dbg_sel = 2'd3;
        step();
        in_valid = 1'b0;
        n_checks++; if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h05, 3'b100}) begin n_fail++; $display("FAIL xor_issue got %h/%h/%h want 05/05/4", alu_a, alu_b, alu_op); end
        step();
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd3, 8'h00}) begin n_fail++; $display("FAIL xor_wb got %b/%h/%h want 1/3/00", wb_valid, wb_rd, wb_data); end
        n_checks++; if ({flag_z, flag_n} !== 2'b10) begin n_fail++; $display("FAIL xor_flags got %b%b want 10", flag_z, flag_n); end
        n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL xor_r3 got %h want 00", dbg_data); end
    endtask

    task automatic test_r0_write();
        // ADD R0 = R0 + 9
        in_valid = 1'b1; in_instr = 16'h0109; dbg_sel = 2'd0;
        step();
        in_valid = 1'b0;
        step();
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd0, 8'h09}) begin n_fail++; $display("FAIL r0_wb got %b/%h/%h want 1/0/09", wb_valid, wb_rd, wb_data); end
        n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL r0_flags got %b%b want 00", flag_z, flag_n); end
        n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL r0_value got %h want 00", dbg_data); end
        n_checks++; if (issue_count !== 16'd7) begin n_fail++; $display("FAIL r0_count got %0d want 7", issue_count); end
    endtask

    task automatic test_hold();
        // ADD R3 = R1 + 1, then stall it in exe for three cycles
        in_valid = 1'b1; in_instr = 16'h1B01; dbg_sel = 2'd3;
        step();
        hold = 1'b1; in_instr = 16'h0905;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL hold_wb[%0d] got %b want 0", i, wb_valid); end
            n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL hold_r3[%0d] got %h want 00", i, dbg_data); end
            n_checks++; if ({alu_a, alu_b, issue_count} !== {8'h05, 8'h01, 16'd8}) begin n_fail++; $display("FAIL hold_frozen[%0d] got %h/%h/%0d want 05/01/8", i, alu_a, alu_b, issue_count); end
        end
        hold = 1'b0; in_valid = 1'b0;
        step();
        n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd3, 8'h06}) begin n_fail++; $display("FAIL hold_release_wb got %b/%h/%h want 1/3/06", wb_valid, wb_rd, wb_data); end
        n_checks++; if (dbg_data !== 8'h06) begin n_fail++; $display("FAIL hold_r3_commit got %h want 06", dbg_data); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL hold_single_commit got %b want 0", wb_valid); end
    endtask

    task automatic test_illegal_and_reset();
        // op 110 targeting R1 must retire without any architectural write
        in_valid = 1'b1; in_instr = 16'hC905; dbg_sel = 2'd1;
        step();
        in_valid = 1'b0;
        n_checks++; if (alu_op !== 3'b110) begin n_fail++; $display("FAIL ill_issue got %h want 6", alu_op); end
        step();
        n_checks++; if ({wb_valid, illegal_op} !== 2'b01) begin n_fail++; $display("FAIL ill_commit got wb=%b ill=%b want 0/1", wb_valid, illegal_op); end
        n_checks++; if ({dbg_data, flag_z, flag_n} !== {8'h05, 2'b00}) begin n_fail++; $display("FAIL ill_state got %h %b%b want 05 00", dbg_data, flag_z, flag_n); end
        step();
        n_checks++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b want 1", illegal_op); end
        // ADD R2 = R0 + 0x44 is in flight when reset hits
        in_valid = 1'b1; in_instr = 16'h1144; dbg_sel = 2'd2;
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({in_ready, alu_a, alu_b, alu_op, wb_valid, wb_data} !== 29'd0) begin n_fail++; $display("FAIL mid_rst_outputs got %b %h %h %h %b %h want 0", in_ready, alu_a, alu_b, alu_op, wb_valid, wb_data); end
        n_checks++; if ({illegal_op, flag_z, flag_n, issue_count} !== 19'd0) begin n_fail++; $display("FAIL mid_rst_state got %b%b%b %0d want 0", illegal_op, flag_z, flag_n, issue_count); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if ({wb_valid, dbg_data} !== 9'd0) begin n_fail++; $display("FAIL mid_rst_no_commit got %b %h want 0 00", wb_valid, dbg_data); end
        dbg_sel = 2'd1; #1;
        n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_r1 got %h want 00", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_back_to_back();
        test_xor_reg();
        test_r0_write();
        test_hold();
        test_illegal_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
